// File: rtl/dma_timing_ctrl_pkg.sv
// Shared types and constants for the 8237-style DMA timing/control sequencer.
package dmaRegConfigPkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } dmaTimingState_t;

  typedef enum logic [1:0] {
    TT_VERIFY = 2'd0,
    TT_WRITE  = 2'd1,
    TT_READ   = 2'd2
  } transferType_t;

  typedef enum logic [1:0] {
    TM_DEMAND = 2'd0,
    TM_SINGLE = 2'd1,
    TM_BLOCK  = 2'd2
  } transferMode_t;

  localparam int CMD_DISABLE_BIT = 2;
  localparam int CMD_ROTATE_BIT  = 4;

  // Encoding 11 of both fields folds onto verify / single respectively.
  function automatic transferType_t decode_type(input logic [1:0] t);
    case (t)
      2'b01:   return TT_WRITE;
      2'b10:   return TT_READ;
      default: return TT_VERIFY;
    endcase
  endfunction

  function automatic transferMode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return TM_DEMAND;
      2'b10:   return TM_BLOCK;
      default: return TM_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/dma_timing_ctrl_priority_encoder.sv
// Picks the first pending channel, searching upward from the rotation pointer.
module dma_priority_encoder #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic [CHANNELS-1:0] i_pending,
  input  logic [CH_W-1:0]     i_rot_ptr,
  output logic [CH_W-1:0]     o_winner,
  output logic                o_valid
);

  logic [CH_W-1:0] w_idx;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    w_idx    = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_idx = i_rot_ptr + CH_W'(i);
      if (i_pending[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_timing_ctrl.sv
// DMA timing and control sequencer: DREQ arbitration, HRQ/HLDA handshake, S1..S4 transfer steps.
// Optional feature: `define ROTATING_PRIORITY_EN to honour commandReg[4] rotating priority.
module dma_timing_ctrl
  import dmaRegConfigPkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [CHANNELS-1:0]        DREQ,
  input  logic                       HLDA,
  input  logic                       EOP_N,
  input  logic [7:0]                 commandReg,
  input  logic [CHANNELS*6-1:0]      modeReg,
  input  logic [CHANNELS-1:0]        maskReg,
  input  logic                       tcReached,
  output logic                       HRQ,
  output logic [CHANNELS-1:0]        DACK,
  output logic                       AEN,
  output logic                       ADSTB,
  output logic                       MEMR_N,
  output logic                       MEMW_N,
  output logic                       IOR_N,
  output logic                       IOW_N,
  output logic                       programCondition,
  output logic                       loadAddr,
  output logic                       incrTemporaryAddressReg,
  output logic                       decrTemporaryWordCountReg,
  output logic                       updateCurrentAddressReg,
  output logic                       updateCurrentWordCountReg,
  output logic                       intEOP,
  output logic [$clog2(CHANNELS)-1:0] activeChannel,
  output logic [2:0]                 o_dbg_state
);

  localparam int CH_W = $clog2(CHANNELS);

  dmaTimingState_t     r_state;
  dmaTimingState_t     w_next_state;
  logic [CH_W-1:0]     r_active;
  logic                r_eop_seen;
  logic [CH_W-1:0]     w_rot_ptr;
  logic [CHANNELS-1:0] w_pending;
  logic [CH_W-1:0]     w_winner;
  logic                w_win_valid;
  logic [5:0]          w_mode_bits;
  transferType_t       w_type;
  transferMode_t       w_mode;
  logic                w_end;
  logic [CHANNELS-1:0] w_dack;

  assign w_pending   = DREQ & ~maskReg;
  assign w_mode_bits = modeReg[6*r_active +: 6];
  assign w_type      = decode_type(w_mode_bits[1:0]);
  assign w_mode      = decode_mode(w_mode_bits[5:4]);
  assign w_end       = tcReached | r_eop_seen | ~EOP_N;
  assign w_dack      = CHANNELS'(1) << r_active;

`ifdef ROTATING_PRIORITY_EN
  logic [CH_W-1:0] r_rot_ptr;

  // The serviced channel drops to lowest priority once its S4 completes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_rot_ptr <= '0;
    else if (r_state == S4 && HLDA) r_rot_ptr <= r_active + 1'b1;
  end

  assign w_rot_ptr = commandReg[CMD_ROTATE_BIT] ? r_rot_ptr : '0;
`else
  assign w_rot_ptr = '0;
`endif

  dma_priority_encoder #(.CHANNELS(CHANNELS), .CH_W(CH_W)) u_prio (
    .i_pending (w_pending),
    .i_rot_ptr (w_rot_ptr),
    .o_winner  (w_winner),
    .o_valid   (w_win_valid)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= SI;
      r_active   <= '0;
      r_eop_seen <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S0 && HLDA && w_win_valid) r_active <= w_winner;
      if (r_state == SI || r_state == S0) r_eop_seen <= 1'b0;
      else if ((r_state == S2 || r_state == S3) && HLDA && !EOP_N) r_eop_seen <= 1'b1;
    end
  end

  // Handshake: HRQ is held from S0 through S4; HLDA high means the bus is ours, and
  // HLDA low at any point in S1..S4 abandons the cycle with no side effects.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SI: if (|w_pending && !commandReg[CMD_DISABLE_BIT]) w_next_state = S0;
      S0: begin
        if (!w_win_valid) w_next_state = SI;
        else if (HLDA)    w_next_state = S1;
      end
      S1: w_next_state = HLDA ? S2 : SI;
      S2: w_next_state = HLDA ? S3 : SI;
      S3: w_next_state = HLDA ? S4 : SI;
      S4: begin
        if (!HLDA || w_end) w_next_state = SI;
        else begin
          case (w_mode)
            TM_BLOCK:  w_next_state = S1;
            TM_DEMAND: w_next_state = DREQ[r_active] ? S1 : SI;
            default:   w_next_state = SI;
          endcase
        end
      end
      default: w_next_state = SI;
    endcase
  end

  always_comb begin
    HRQ                       = 1'b0;
    DACK                      = '0;
    AEN                       = 1'b0;
    ADSTB                     = 1'b0;
    MEMR_N                    = 1'b1;
    MEMW_N                    = 1'b1;
    IOR_N                     = 1'b1;
    IOW_N                     = 1'b1;
    programCondition          = 1'b0;
    loadAddr                  = 1'b0;
    incrTemporaryAddressReg   = 1'b0;
    decrTemporaryWordCountReg = 1'b0;
    updateCurrentAddressReg   = 1'b0;
    updateCurrentWordCountReg = 1'b0;
    intEOP                    = 1'b0;
    case (r_state)
      SI: programCondition = 1'b1;
      S0: HRQ = 1'b1;
      S1: begin
        HRQ      = 1'b1;
        AEN      = 1'b1;
        ADSTB    = 1'b1;
        loadAddr = HLDA;
      end
      S2, S3: begin
        HRQ  = 1'b1;
        DACK = w_dack;
        if (HLDA && w_type == TT_WRITE) begin
          IOR_N  = 1'b0;
          MEMW_N = (r_state != S3);
        end
        if (HLDA && w_type == TT_READ) begin
          MEMR_N = 1'b0;
          IOW_N  = (r_state != S3);
        end
      end
      S4: begin
        HRQ                       = 1'b1;
        DACK                      = w_dack;
        incrTemporaryAddressReg   = HLDA;
        decrTemporaryWordCountReg = HLDA;
        updateCurrentAddressReg   = HLDA;
        updateCurrentWordCountReg = HLDA;
        intEOP                    = HLDA & w_end;
      end
      default: ;
    endcase
  end

  assign activeChannel = r_active;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed bench for dma_timing_ctrl: priority table plus hand-written transfer sequences.
module tb_dma_timing_ctrl;
  import dmaRegConfigPkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  DREQ;
  logic        HLDA;
  logic        EOP_N;
  logic [7:0]  commandReg;
  logic [23:0] modeReg;
  logic [3:0]  maskReg;
  logic        tcReached;
  logic        HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N;
  logic [3:0]  DACK;
  logic        programCondition, loadAddr, incrTemporaryAddressReg, decrTemporaryWordCountReg;
  logic        updateCurrentAddressReg, updateCurrentWordCountReg, intEOP;
  logic [1:0]  activeChannel;
  logic [2:0]  o_dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  dma_timing_ctrl #(.CHANNELS(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N(EOP_N),
    .commandReg(commandReg), .modeReg(modeReg), .maskReg(maskReg), .tcReached(tcReached),
    .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
    .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .programCondition(programCondition), .loadAddr(loadAddr),
    .incrTemporaryAddressReg(incrTemporaryAddressReg),
    .decrTemporaryWordCountReg(decrTemporaryWordCountReg),
    .updateCurrentAddressReg(updateCurrentAddressReg),
    .updateCurrentWordCountReg(updateCurrentWordCountReg),
    .intEOP(intEOP), .activeChannel(activeChannel), .o_dbg_state(o_dbg_state)
  );

  localparam logic [31:0] RESET_VEC = {9'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1,
                                       6'b000000, 2'b00, 3'b000};

  typedef struct {
    logic [3:0] dreq;
    logic [3:0] mask;
    logic [7:0] cmd;
    logic       exp_hrq;
    logic [1:0] exp_ch;
  } prio_vec_t;

  prio_vec_t vecs[8];
  logic [1:0] exp_order[4];

  function automatic logic [31:0] outs();
    return {9'b0, HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, programCondition,
            loadAddr, incrTemporaryAddressReg, decrTemporaryWordCountReg,
            updateCurrentAddressReg, updateCurrentWordCountReg, intEOP, activeChannel,
            o_dbg_state};
  endfunction

  function automatic logic [5:0] mb(input logic [1:0] mode, input logic [1:0] ttype);
    return {mode, 2'b00, ttype};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N    = 1'b0;
    DREQ       = '0;
    HLDA       = 1'b0;
    EOP_N      = 1'b1;
    commandReg = '0;
    maskReg    = '0;
    tcReached  = 1'b0;
    modeReg    = '0;
    step();
    step();
    RESET_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 4'b0000, 8'h00, 1'b1, 2'd0};
    vecs[1] = '{4'b1010, 4'b0000, 8'h00, 1'b1, 2'd1};
    vecs[2] = '{4'b1010, 4'b0010, 8'h00, 1'b1, 2'd3};
    vecs[3] = '{4'b1010, 4'b0000, 8'h04, 1'b0, 2'd0};
    vecs[4] = '{4'b1100, 4'b0000, 8'h00, 1'b1, 2'd2};
    vecs[5] = '{4'b1111, 4'b0111, 8'h00, 1'b1, 2'd3};
    vecs[6] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0};
    vecs[7] = '{4'b0001, 4'b0001, 8'h00, 1'b0, 2'd0};
`ifdef ROTATING_PRIORITY_EN
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset values
    do_reset();
    chk("reset_outputs", outs(), RESET_VEC);

    // Priority table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      modeReg    = {4{mb(2'b01, 2'b10)}};
      DREQ       = vecs[v].dreq;
      maskReg    = vecs[v].mask;
      commandReg = vecs[v].cmd;
      step();
      chk($sformatf("prio%0d_hrq", v), HRQ, vecs[v].exp_hrq);
      if (vecs[v].exp_hrq) begin
        HLDA = 1'b1;
        step();
        chk($sformatf("prio%0d_state", v), o_dbg_state, S1);
        chk($sformatf("prio%0d_ch", v), activeChannel, vecs[v].exp_ch);
        HLDA = 1'b0;
        DREQ = '0;
        step();
        chk($sformatf("prio%0d_abort", v), o_dbg_state, SI);
      end else begin
        step();
        chk($sformatf("prio%0d_hrq_hold", v), HRQ, 1'b0);
      end
    end

    // Single read, channel 0
    do_reset();
    modeReg[5:0] = mb(2'b01, 2'b10);
    DREQ = 4'b0001;
    step();
    chk("single_s0", o_dbg_state, S0);
    chk("single_hrq", HRQ, 1'b1);
    HLDA = 1'b1;
    step();
    chk("single_s1", {o_dbg_state, AEN, ADSTB, loadAddr}, {S1, 3'b111});
    step();
    chk("single_s2", {o_dbg_state, DACK, MEMR_N, IOW_N}, {S2, 4'b0001, 2'b01});
    step();
    chk("single_s3", {o_dbg_state, DACK, MEMR_N, IOW_N}, {S3, 4'b0001, 2'b00});
    step();
    chk("single_s4", {o_dbg_state, DACK, incrTemporaryAddressReg, decrTemporaryWordCountReg,
        updateCurrentAddressReg, updateCurrentWordCountReg, intEOP, MEMR_N},
        {S4, 4'b0001, 4'b1111, 1'b0, 1'b1});
    step();
    chk("single_end", {o_dbg_state, HRQ, DACK, programCondition, incrTemporaryAddressReg},
        {SI, 1'b0, 4'b0000, 1'b1, 1'b0});
    DREQ = '0;
    HLDA = 1'b0;

    // Block write, channel 2, terminal count on the third word
    do_reset();
    modeReg[17:12] = mb(2'b10, 2'b01);
    DREQ = 4'b0100;
    step();
    HLDA = 1'b1;
    step();
    chk("block_ch", activeChannel, 2'd2);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("block%0d_s1", w), {o_dbg_state, loadAddr}, {S1, 1'b1});
      step();
      chk($sformatf("block%0d_s2", w), {o_dbg_state, DACK, IOR_N, MEMW_N}, {S2, 4'b0100, 2'b01});
      step();
      chk($sformatf("block%0d_s3", w), {o_dbg_state, IOR_N, MEMW_N}, {S3, 2'b00});
      step();
      if (w == 2) begin
        tcReached = 1'b1;
        #1;
      end
      chk($sformatf("block%0d_s4", w), {o_dbg_state, incrTemporaryAddressReg, intEOP},
          {S4, 1'b1, (w == 2)});
      step();
    end
    chk("block_done", {o_dbg_state, HRQ}, {SI, 1'b0});
    tcReached = 1'b0;
    DREQ = '0;
    HLDA = 1'b0;

    // Rotation: two channels held pending, single mode
    do_reset();
    modeReg    = {4{mb(2'b01, 2'b10)}};
    commandReg = 8'h10;
    DREQ       = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10 && !HRQ; i++) step();
      chk($sformatf("rot%0d_hrq", k), HRQ, 1'b1);
      HLDA = 1'b1;
      step();
      chk($sformatf("rot%0d_ch", k), activeChannel, exp_order[k]);
      step();
      step();
      step();
      step();
      chk($sformatf("rot%0d_idle", k), {o_dbg_state, HRQ}, {SI, 1'b0});
      HLDA = 1'b0;
    end
    DREQ = '0;

    // HLDA dropped in S2
    do_reset();
    modeReg[5:0] = mb(2'b10, 2'b10);
    DREQ = 4'b0001;
    step();
    HLDA = 1'b1;
    step();
    step();
    chk("abort_s2", o_dbg_state, S2);
    HLDA = 1'b0;
    #1;
    chk("abort_quiet", {MEMR_N, incrTemporaryAddressReg, intEOP}, 3'b100);
    step();
    chk("abort_si", {o_dbg_state, incrTemporaryAddressReg}, {SI, 1'b0});
    DREQ = '0;

    // External EOP in S3 of a block transfer
    do_reset();
    modeReg[5:0] = mb(2'b10, 2'b10);
    DREQ = 4'b0001;
    step();
    HLDA = 1'b1;
    step();
    step();
    step();
    chk("eop_s3", o_dbg_state, S3);
    EOP_N = 1'b0;
    step();
    EOP_N = 1'b1;
    #1;
    chk("eop_s4", {o_dbg_state, intEOP}, {S4, 1'b1});
    step();
    chk("eop_si", {o_dbg_state, HRQ}, {SI, 1'b0});
    DREQ = '0;
    HLDA = 1'b0;

    // Asynchronous reset in S3
    do_reset();
    modeReg[5:0] = mb(2'b01, 2'b10);
    DREQ = 4'b0001;
    step();
    HLDA = 1'b1;
    step();
    step();
    step();
    chk("areset_s3", {o_dbg_state, MEMR_N}, {S3, 1'b0});
    #2;
    RESET_N = 1'b0;
    #1;
    chk("areset_outputs", outs(), RESET_VEC);
    RESET_N = 1'b1;
    DREQ = '0;
    HLDA = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
